// File: rtl/cc_pkg.sv
// Shared definitions for the integer condition-code / branch control slice.
//   - Bicc condition field encodings (4 bits)
//   - branch FSM state encoding (2 bits)
//   - ALU op bit positions that identify a modify-cc operation
//   - packed N/Z/C/V flag bundle used for icc and the ALU flag inputs
package cc_pkg;

  // Bicc cond field. Bit 3 inverts the sense of the condition selected by bits [2:0].
  localparam logic [3:0] BN   = 4'b0000;
  localparam logic [3:0] BE   = 4'b0001;
  localparam logic [3:0] BLE  = 4'b0010;
  localparam logic [3:0] BL   = 4'b0011;
  localparam logic [3:0] BLEU = 4'b0100;
  localparam logic [3:0] BCS  = 4'b0101;
  localparam logic [3:0] BNEG = 4'b0110;
  localparam logic [3:0] BVS  = 4'b0111;
  localparam logic [3:0] BA   = 4'b1000;
  localparam logic [3:0] BNE  = 4'b1001;
  localparam logic [3:0] BG   = 4'b1010;
  localparam logic [3:0] BGE  = 4'b1011;
  localparam logic [3:0] BGU  = 4'b1100;
  localparam logic [3:0] BCC  = 4'b1101;
  localparam logic [3:0] BPOS = 4'b1110;
  localparam logic [3:0] BVC  = 4'b1111;

  // ALU op field: op[4]=1 with op[5]=0 marks an op that updates icc.
  localparam int ALU_OP_CC_BIT    = 4;
  localparam int ALU_OP_LOGIC_BIT = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_SLOT_EXEC  = 2'b01,
    ST_SLOT_ANNUL = 2'b10
  } br_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } cc_flags_t;

  // Decode helper for the issue/decode side that generates cc_we.
  function automatic logic is_modify_cc(input logic [5:0] op);
    return op[ALU_OP_CC_BIT] & ~op[ALU_OP_LOGIC_BIT];
  endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational Bicc/Ticc condition evaluator.
// Ports:
//   flags  in   N/Z/C/V to evaluate against
//   cond   in   4-bit Bicc/Ticc cond field
//   taken  out  1 when the condition holds
module cc_cond_eval
  import cc_pkg::*;
(
  input  cc_flags_t  flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic base;

  // Each code and its bit-3 complement share one base condition; bit 3 then
  // flips the sense, so BA is the inverse of BN, BNE of BE, and so on.
  always_comb begin
    base = 1'b0;
    unique case (cond)
      BN,   BA:  base = 1'b0;
      BE,   BNE: base = flags.z;
      BLE,  BG:  base = flags.z | (flags.n ^ flags.v);
      BL,   BGE: base = flags.n ^ flags.v;
      BLEU, BGU: base = flags.c | flags.z;
      BCS,  BCC: base = flags.c;
      BNEG, BPOS: base = flags.n;
      BVS,  BVC: base = flags.v;
    endcase
    taken = base ^ cond[3];
  end

endmodule

// File: rtl/cc_branch_ctrl.sv
// Condition-code register and Bicc branch control for the EX stage.
// Latches ALU N/Z/C/V into icc, feeds icc.C back as ALU carry-in, evaluates
// Bicc conditions, issues a one-cycle PC redirect and sequences the delay
// slot (executed or annulled).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ex_valid, stall       EX occupancy and hold; adv = ex_valid & ~stall
//   cc_we                 EX op updates icc
//   alu_n/z/c/v           ALU flags of the EX op
//   br_valid              EX op is a Bicc
//   br_cond, br_annul     Bicc cond field and 'a' bit
//   br_target             branch target
//   icc_n/z/c/v           registered condition codes
//   carry_to_alu          icc.C for add/sub-with-carry
//   redirect, redirect_pc one-cycle fetch redirect and its target
//   kill_ex               current EX instruction is annulled
//   dcti_err              sticky: branch found in a delay slot
module cc_branch_ctrl
  import cc_pkg::*;
#(
  parameter int DW     = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic          stall,
  input  logic          cc_we,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic          br_valid,
  input  logic [3:0]    br_cond,
  input  logic          br_annul,
  input  logic [DW-1:0] br_target,
  output logic          icc_n,
  output logic          icc_z,
  output logic          icc_c,
  output logic          icc_v,
  output logic          carry_to_alu,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc,
  output logic          kill_ex,
  output logic          dcti_err
);

  br_state_t state_q, state_d;
  cc_flags_t icc_q;
  cc_flags_t alu_f;
  cc_flags_t eval_f;
  logic      adv;
  logic      icc_we;
  logic      taken;
  logic      redirect_d;
  logic      dcti_set;

  // Datapath side: advance qualifier, slot annul, icc write enable and the
  // bypass mux that lets a branch see flags produced in the same cycle.
  always_comb begin
    alu_f   = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
    adv     = ex_valid & ~stall;
    kill_ex = (state_q == ST_SLOT_ANNUL) & ex_valid;
    icc_we  = adv & cc_we & ~kill_ex;
    eval_f  = (BYPASS && cc_we) ? alu_f : icc_q;
  end

  cc_cond_eval u_cond_eval (
    .flags (eval_f),
    .cond  (br_cond),
    .taken (taken)
  );

  // Branch sequencing. Only RUN evaluates branches; a branch arriving while
  // a delay slot is pending is treated as a DCTI error and otherwise ignored.
  // BA with the annul bit is the one taken case that annuls its slot.
  always_comb begin
    state_d    = state_q;
    redirect_d = 1'b0;
    dcti_set   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (adv && br_valid) begin
          if (taken) begin
            redirect_d = 1'b1;
            state_d    = (br_cond == BA && br_annul) ? ST_SLOT_ANNUL : ST_SLOT_EXEC;
          end else begin
            state_d = br_annul ? ST_SLOT_ANNUL : ST_RUN;
          end
        end
      end
      ST_SLOT_EXEC, ST_SLOT_ANNUL: begin
        if (adv) begin
          state_d  = ST_RUN;
          dcti_set = br_valid;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, icc and redirect registers. redirect is recomputed every cycle
  // (not gated by adv) so it stays a single pulse even if EX stalls next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      icc_q       <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      dcti_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      redirect <= redirect_d;
      if (icc_we) begin
        icc_q <= alu_f;
      end
      if (redirect_d) begin
        redirect_pc <= br_target;
      end
      if (dcti_set) begin
        dcti_err <= 1'b1;
      end
    end
  end

  assign icc_n        = icc_q.n;
  assign icc_z        = icc_q.z;
  assign icc_c        = icc_q.c;
  assign icc_v        = icc_q.v;
  assign carry_to_alu = icc_q.c;

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Directed self-checking bench for cc_branch_ctrl. Two instances share all
// inputs: dut (BYPASS=1) and dut0 (BYPASS=0).
module tb_cc_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        stall = 1'b0;
  logic        cc_we = 1'b0;
  logic        alu_n = 1'b0;
  logic        alu_z = 1'b0;
  logic        alu_c = 1'b0;
  logic        alu_v = 1'b0;
  logic        br_valid = 1'b0;
  logic [3:0]  br_cond = 4'd0;
  logic        br_annul = 1'b0;
  logic [31:0] br_target = 32'd0;

  logic        icc_n, icc_z, icc_c, icc_v, carry_to_alu;
  logic        redirect, kill_ex, dcti_err;
  logic [31:0] redirect_pc;
  logic        icc_n0, icc_z0, icc_c0, icc_v0, carry_to_alu0;
  logic        redirect0, kill_ex0, dcti_err0;
  logic [31:0] redirect_pc0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cc_branch_ctrl #(.DW(32), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall(stall), .cc_we(cc_we),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .br_valid(br_valid), .br_cond(br_cond), .br_annul(br_annul), .br_target(br_target),
    .icc_n(icc_n), .icc_z(icc_z), .icc_c(icc_c), .icc_v(icc_v),
    .carry_to_alu(carry_to_alu), .redirect(redirect), .redirect_pc(redirect_pc),
    .kill_ex(kill_ex), .dcti_err(dcti_err)
  );

  cc_branch_ctrl #(.DW(32), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall(stall), .cc_we(cc_we),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .br_valid(br_valid), .br_cond(br_cond), .br_annul(br_annul), .br_target(br_target),
    .icc_n(icc_n0), .icc_z(icc_z0), .icc_c(icc_c0), .icc_v(icc_v0),
    .carry_to_alu(carry_to_alu0), .redirect(redirect0), .redirect_pc(redirect_pc0),
    .kill_ex(kill_ex0), .dcti_err(dcti_err0)
  );

  // Reference Bicc table, written out per code.
  function automatic logic ref_taken(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return z | (n ^ v);
      4'd3:  return n ^ v;
      4'd4:  return c | z;
      4'd5:  return c;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return ~z;
      4'd10: return ~(z | (n ^ v));
      4'd11: return ~(n ^ v);
      4'd12: return ~(c | z);
      4'd13: return ~c;
      4'd14: return ~n;
      default: return ~v;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_valid = 1'b0; stall = 1'b0; cc_we = 1'b0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    br_valid = 1'b0; br_cond = 4'd0; br_annul = 1'b0; br_target = 32'd0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_cc(input logic [3:0] nzcv);
    clear_in();
    ex_valid = 1'b1; cc_we = 1'b1;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
  endtask

  task automatic drive_br(input logic [3:0] cond, input logic a, input logic [31:0] tgt);
    clear_in();
    ex_valid = 1'b1; br_valid = 1'b1;
    br_cond = cond; br_annul = a; br_target = tgt;
  endtask

  task automatic drive_nop();
    clear_in();
    ex_valid = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({icc_n, icc_z, icc_c, icc_v, redirect, dcti_err} !== 6'b0 || redirect_pc !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: icc=%b redirect=%b pc=%h dcti=%b, want all zero",
               {icc_n, icc_z, icc_c, icc_v}, redirect, redirect_pc, dcti_err);
    end
    drive_cc(4'b0101);
    tick();
    checks++;
    if ({icc_n, icc_z, icc_c, icc_v} !== 4'b0101 || carry_to_alu !== 1'b0) begin
      failures++;
      $display("[TB] FAIL icc_load: icc=%b ci=%b, want 0101 ci=0", {icc_n, icc_z, icc_c, icc_v}, carry_to_alu);
    end
    drive_br(4'b1000, 1'b1, 32'h0000_0100);
    tick();
    drive_nop();
    #1;
    checks++;
    if (kill_ex !== 1'b1 || redirect !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ba_annul_slot: kill=%b redirect=%b, want 1 1", kill_ex, redirect);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (kill_ex !== 1'b0 || redirect !== 1'b0 || {icc_n, icc_z, icc_c, icc_v} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_mid_slot: kill=%b redirect=%b icc=%b, want 0 0 0000",
               kill_ex, redirect, {icc_n, icc_z, icc_c, icc_v});
    end
  endtask

  task automatic test_be_redirect();
    do_reset();
    drive_cc(4'b0100);
    tick();
    checks++;
    if ({icc_n, icc_z, icc_c, icc_v} !== 4'b0100 || {icc_n0, icc_z0, icc_c0, icc_v0} !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL be_icc: icc=%b icc0=%b, want 0100",
               {icc_n, icc_z, icc_c, icc_v}, {icc_n0, icc_z0, icc_c0, icc_v0});
    end
    drive_br(4'b0001, 1'b0, 32'h0000_0040);
    tick();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h40 || redirect0 !== 1'b1 || redirect_pc0 !== 32'h40) begin
      failures++;
      $display("[TB] FAIL be_redirect: rd=%b pc=%h rd0=%b pc0=%h, want 1 00000040",
               redirect, redirect_pc, redirect0, redirect_pc0);
    end
    drive_nop();
    #1;
    checks++;
    if (kill_ex !== 1'b0) begin
      failures++;
      $display("[TB] FAIL be_slot_kill: kill=%b, want 0", kill_ex);
    end
    tick();
    checks++;
    if (redirect !== 1'b0 || kill_ex !== 1'b0) begin
      failures++;
      $display("[TB] FAIL be_after_slot: rd=%b kill=%b, want 0 0", redirect, kill_ex);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive_cc(4'b1000);
    br_valid = 1'b1; br_cond = 4'b0011; br_target = 32'h0000_0080;
    tick();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin
      failures++;
      $display("[TB] FAIL bypass_taken: rd=%b pc=%h, want 1 00000080", redirect, redirect_pc);
    end
    checks++;
    if (redirect0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nobypass_not_taken: rd0=%b, want 0", redirect0);
    end
    checks++;
    if ({icc_n0, icc_z0, icc_c0, icc_v0} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL nobypass_icc: icc0=%b, want 1000", {icc_n0, icc_z0, icc_c0, icc_v0});
    end
    drive_nop();
    tick();
  endtask

  task automatic test_annul_not_taken();
    do_reset();
    drive_cc(4'b0100);
    tick();
    drive_br(4'b1001, 1'b1, 32'h0000_0200);
    tick();
    checks++;
    if (redirect !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bne_no_redirect: rd=%b, want 0", redirect);
    end
    drive_cc(4'b1111);
    #1;
    checks++;
    if (kill_ex !== 1'b1 || kill_ex0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bne_slot_kill: kill=%b kill0=%b, want 1", kill_ex, kill_ex0);
    end
    tick();
    checks++;
    if ({icc_n, icc_z, icc_c, icc_v} !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL killed_cc_write: icc=%b, want 0100", {icc_n, icc_z, icc_c, icc_v});
    end
    drive_nop();
    #1;
    checks++;
    if (kill_ex !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bne_after_slot: kill=%b, want 0", kill_ex);
    end
    tick();
  endtask

  task automatic test_stall_annul();
    int pulses;
    do_reset();
    pulses = 0;
    drive_br(4'b1000, 1'b1, 32'h0000_0300);
    tick();
    pulses += int'(redirect);
    checks++;
    if (redirect_pc !== 32'h300) begin
      failures++;
      $display("[TB] FAIL ba_pc: pc=%h, want 00000300", redirect_pc);
    end
    clear_in();
    #1;
    checks++;
    if (kill_ex !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bubble_kill: kill=%b, want 0", kill_ex);
    end
    tick();
    pulses += int'(redirect);
    drive_nop();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (kill_ex !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_kill_%0d: kill=%b, want 1", i, kill_ex);
      end
      tick();
      pulses += int'(redirect);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (kill_ex !== 1'b1) begin
      failures++;
      $display("[TB] FAIL slot_release_kill: kill=%b, want 1", kill_ex);
    end
    tick();
    pulses += int'(redirect);
    #1;
    checks++;
    if (kill_ex !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_back_to_run: kill=%b, want 0", kill_ex);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL redirect_pulses: count=%0d, want 1", pulses);
    end
    tick();
  endtask

  task automatic test_dcti_err();
    do_reset();
    drive_br(4'b1000, 1'b0, 32'h0000_0400);
    tick();
    drive_br(4'b1000, 1'b0, 32'h0000_0500);
    #1;
    checks++;
    if (kill_ex !== 1'b0 || redirect !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dcti_slot: kill=%b rd=%b, want 0 1", kill_ex, redirect);
    end
    tick();
    checks++;
    if (dcti_err !== 1'b1 || redirect !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dcti_flag: err=%b rd=%b, want 1 0", dcti_err, redirect);
    end
    drive_nop();
    tick();
    tick();
    checks++;
    if (dcti_err !== 1'b1 || redirect !== 1'b0 || redirect_pc !== 32'h400) begin
      failures++;
      $display("[TB] FAIL dcti_sticky: err=%b rd=%b pc=%h, want 1 0 00000400", dcti_err, redirect, redirect_pc);
    end
    do_reset();
    checks++;
    if (dcti_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dcti_reset: err=%b, want 0", dcti_err);
    end
  endtask

  task automatic test_cond_sweep();
    logic exp;
    do_reset();
    for (int cond = 0; cond < 16; cond++) begin
      for (int f = 0; f < 16; f++) begin
        drive_cc(f[3:0]);
        br_valid = 1'b1; br_cond = cond[3:0]; br_target = 32'h1000 + 32'(cond * 16 + f);
        exp = ref_taken(cond[3:0], f[3:0]);
        tick();
        checks++;
        if (redirect !== exp) begin
          failures++;
          $display("[TB] FAIL sweep cond=%b nzcv=%b: rd=%b, want %b", cond[3:0], f[3:0], redirect, exp);
        end
        drive_nop();
        tick();
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_be_redirect();
    test_bypass();
    test_annul_not_taken();
    test_stall_annul();
    test_dcti_err();
    test_cond_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
